uart_cmd_bridge: RTL and testbench
==================================

// Module: uart_cmd_bridge
// PURPOSE
//  Downstream consumer of the uart block's RX FIFO and producer for its TX FIFO. Parses a byte-level
//  host command protocol (write/read one byte at a 16-bit address) and drives a simple single-beat
//  register/memory bus into the VIC register file and video RAM. Sends one response byte per command.
//  Lets a PC poke/peek VIC state over serial without a soft CPU.
// PARAMETERS
//  ADDR_W    16         bus address width (1..16); low ADDR_W bits of the received 16-bit address used
//  TO_CYCLES 1_000_000  inter-byte / read-response timeout in clk cycles (>=4)
//  TO_BIT    20         width of timeout counter; 2^TO_BIT > TO_CYCLES
// PORTS
//  clk         in   1       system clock (same domain as uart)
//  reset_n     in   1       asynchronous reset, active low
//  rx_empty    in   1       uart RX FIFO empty
//  r_data      in   8       uart RX FIFO head byte (show-ahead, valid when !rx_empty)
//  rd_uart     out  1       pop RX FIFO (1-cycle pulse)
//  tx_full     in   1       uart TX FIFO full
//  w_data      out  8       byte to TX FIFO
//  wr_uart     out  1       push TX FIFO (1-cycle pulse)
//  bus_addr    out  ADDR_W  bus address
//  bus_wdata   out  8       bus write data
//  bus_we      out  1       bus write strobe (1 cycle)
//  bus_re      out  1       bus read strobe (1 cycle)
//  bus_rdata   in   8       bus read data, valid with bus_rvalid
//  bus_rvalid  in   1       read data valid; sampled only in WAIT_RD
//  busy        out  1       high whenever state != IDLE
//  err_pulse   out  1       1-cycle pulse on bad opcode or any timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (w_data, bus_addr, bus_wdata = 0); counter=0. Reset mid-command
//   discards the partial command; no response is sent.
//  Protocol: 'W'(0x57) AH AL D -> write, reply 'K'(0x4B). 'R'(0x52) AH AL -> read, reply data byte.
//   Other opcode -> reply '?'(0x3F). Read timeout -> reply '!'(0x21). Inter-byte timeout -> no reply.
//  Byte consume: in a receive state with !rx_empty, rd_uart=1 that cycle, r_data latched, state advances
//   next cycle. Max one byte per cycle. rd_uart never asserted when rx_empty or outside receive states.
//  FSM: IDLE -(byte=W/R)-> ADDR_HI; IDLE -(other byte)-> TX_RESP('?'), err_pulse.
//   ADDR_HI -(byte)-> ADDR_LO -(byte)-> DATA if W, BUS_RD if R. DATA -(byte)-> BUS_WR.
//   BUS_WR: bus_we=1 for exactly one cycle with bus_addr/bus_wdata stable -> TX_RESP('K').
//   BUS_RD: bus_re=1 for exactly one cycle -> WAIT_RD. WAIT_RD: on bus_rvalid latch bus_rdata ->
//   TX_RESP(data); rvalid earliest 1 cycle after bus_re; rvalid outside WAIT_RD ignored.
//   TX_RESP: when !tx_full, wr_uart=1 and w_data=response for one cycle -> IDLE; else hold (no timeout).
//  Timeout: counter cleared on state entry and on every consumed byte; counts in ADDR_HI/ADDR_LO/DATA/
//   WAIT_RD. Reaching TO_CYCLES-1: receive states -> IDLE (err_pulse, no reply); WAIT_RD -> TX_RESP('!').
//  IDLE never times out. Opcode compare is exact (lower case rejected). Address = {AH,AL}[ADDR_W-1:0].
//  bus_addr/bus_wdata hold last values between transactions. busy=1 in every non-IDLE state.
//  Back-to-back commands: next opcode consumed earliest the cycle after TX_RESP returns to IDLE.
// STRUCTURE
//  Package uart_bridge_pkg: opcode/response constants (OP_WR, OP_RD, RSP_OK, RSP_BAD, RSP_TO) and FSM
//   state encoding (8 states, 3 bits).
//  Sub-module timeout_counter (TO_CYCLES, TO_BIT): sync clear + enable, 1-cycle expire pulse.
//  Top: FSM + latches for opcode, address, data, response byte.
// TESTING
//  1 Write: RX 57 12 34 A5 -> one bus_we, bus_addr=0x1234, bus_wdata=0xA5; TX 4B; 4 rd_uart pulses.
//  2 Read: RX 52 00 10, bus_rdata=0x3C with rvalid 3 cycles after bus_re -> one bus_re; TX 3C.
//  3 Bad opcode: RX 41 -> TX 3F, err_pulse once, no bus strobe; following 52 00 00 works normally.
//  4 Timeouts (TO_CYCLES=16): RX 57 12 then silence -> IDLE after 16 cycles, err_pulse, no TX;
//    read with no rvalid -> TX 21 at timeout.
//  5 Backpressure: tx_full=1 during response for 50 cycles -> wr_uart stays 0, busy=1; release ->
//    exactly one wr_uart; RX bytes queued meanwhile not popped until IDLE.
//  6 Reset: reset_n low after 57 12 -> outputs 0, IDLE; next 57 00 01 FF -> bus write 0x0001=0xFF, TX 4B.

Source files
------------

// File: rtl/uart_cmd_bridge_pkg.sv
// Shared constants and FSM encoding for the serial command bridge.
// Opcodes and response bytes are the ASCII values a host terminal script sends and expects.
package uart_bridge_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_TO  = 8'h21;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_WAIT_RD,
        ST_TX_RESP
    } state_e;

endpackage

// File: rtl/uart_cmd_bridge_if.sv
// UART FIFO and register-bus signals seen by the command bridge.
// The master side is the bridge; the slave side is the uart FIFOs plus the register/VRAM bus.
interface uart_cmd_bridge_if #(
    parameter int ADDR_W = 16
);
    logic              rx_empty;
    logic [7:0]        r_data;
    logic              rd_uart;
    logic              tx_full;
    logic [7:0]        w_data;
    logic              wr_uart;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [7:0]        bus_rdata;
    logic              bus_rvalid;

    modport master (
        input  rx_empty, r_data, tx_full, bus_rdata, bus_rvalid,
        output rd_uart, w_data, wr_uart, bus_addr, bus_wdata, bus_we, bus_re
    );

    modport slave (
        output rx_empty, r_data, tx_full, bus_rdata, bus_rvalid,
        input  rd_uart, w_data, wr_uart, bus_addr, bus_wdata, bus_we, bus_re
    );
endinterface

// File: rtl/uart_cmd_bridge_timeout_counter.sv
// Idle-cycle counter for the bridge; expire_o pulses on the enabled cycle where the count
// reaches TO_CYCLES-1, after which the count restarts from zero.
module timeout_counter #(
    parameter int TO_CYCLES = 1_000_000,
    parameter int TO_BIT    = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam logic [TO_BIT-1:0] TERM = TO_BIT'(TO_CYCLES - 1);

    logic [TO_BIT-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = expire_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_cmd_bridge.sv
// Serial command bridge: parses W/R byte commands from the uart RX FIFO, runs one bus beat,
// and returns one response byte through the TX FIFO.
//  state      | meaning
//  IDLE       | wait for opcode byte
//  ADDR_HI/LO | collect address bytes (timed)
//  DATA       | collect write data byte (timed)
//  BUS_WR/RD  | one-cycle bus strobe
//  WAIT_RD    | wait for bus_rvalid (timed, '!' on expiry)
//  TX_RESP    | push response byte when TX FIFO has room
module uart_cmd_bridge
    import uart_bridge_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int TO_CYCLES = 1_000_000,
    parameter int TO_BIT    = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_cmd_bridge_if.master  bif,
    output logic               busy_o,
    output logic               err_pulse_o
);
    state_e            state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [7:0]        ah_q, ah_d;
    logic [7:0]        al_q, al_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rsp_q, rsp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       rd_addr_full, wr_addr_full;
    logic              rx_state, timed, byte_ok, expire, to_clr;

    assign rx_state     = state_q inside {ST_IDLE, ST_ADDR_HI, ST_ADDR_LO, ST_DATA};
    assign timed        = state_q inside {ST_ADDR_HI, ST_ADDR_LO, ST_DATA, ST_WAIT_RD};
    assign byte_ok      = rx_state && !bif.rx_empty;
    assign to_clr       = byte_ok || (state_d != state_q);
    assign rd_addr_full = {ah_q, bif.r_data};
    assign wr_addr_full = {ah_q, al_q};

    timeout_counter #(
        .TO_CYCLES (TO_CYCLES),
        .TO_BIT    (TO_BIT)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (to_clr),
        .en_i     (timed),
        .expire_o (expire)
    );

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        ah_d        = ah_q;
        al_d        = al_q;
        wdata_d     = wdata_q;
        rsp_d       = rsp_q;
        addr_d      = addr_q;
        err_pulse_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (byte_ok) begin
                    if (bif.r_data == OP_WR || bif.r_data == OP_RD) begin
                        is_wr_d = (bif.r_data == OP_WR);
                        state_d = ST_ADDR_HI;
                    end else begin
                        rsp_d       = RSP_BAD;
                        err_pulse_o = 1'b1;
                        state_d     = ST_TX_RESP;
                    end
                end
            end
            ST_ADDR_HI: begin
                if (byte_ok) begin
                    ah_d    = bif.r_data;
                    state_d = ST_ADDR_LO;
                end else if (expire) begin
                    err_pulse_o = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_ADDR_LO: begin
                if (byte_ok) begin
                    al_d = bif.r_data;
                    if (is_wr_q) begin
                        state_d = ST_DATA;
                    end else begin
                        addr_d  = rd_addr_full[ADDR_W-1:0];
                        state_d = ST_BUS_RD;
                    end
                end else if (expire) begin
                    err_pulse_o = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DATA: begin
                // Bus address/data only move when a strobe follows, so they hold between commands.
                if (byte_ok) begin
                    addr_d  = wr_addr_full[ADDR_W-1:0];
                    wdata_d = bif.r_data;
                    state_d = ST_BUS_WR;
                end else if (expire) begin
                    err_pulse_o = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_BUS_WR: begin
                rsp_d   = RSP_OK;
                state_d = ST_TX_RESP;
            end
            ST_BUS_RD: begin
                state_d = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (bif.bus_rvalid) begin
                    rsp_d   = bif.bus_rdata;
                    state_d = ST_TX_RESP;
                end else if (expire) begin
                    rsp_d       = RSP_TO;
                    err_pulse_o = 1'b1;
                    state_d     = ST_TX_RESP;
                end
            end
            ST_TX_RESP: begin
                if (!bif.tx_full) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            ah_q    <= 8'h00;
            al_q    <= 8'h00;
            wdata_q <= 8'h00;
            rsp_q   <= 8'h00;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            ah_q    <= ah_d;
            al_q    <= al_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
            addr_q  <= addr_d;
        end
    end

    assign bif.rd_uart   = byte_ok;
    assign bif.wr_uart   = (state_q == ST_TX_RESP) && !bif.tx_full;
    assign bif.w_data    = rsp_q;
    assign bif.bus_we    = (state_q == ST_BUS_WR);
    assign bif.bus_re    = (state_q == ST_BUS_RD);
    assign bif.bus_addr  = addr_q;
    assign bif.bus_wdata = wdata_q;
    assign busy_o        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge: RX FIFO / TX sink / bus slave models with scoreboard queues,
// a table of single commands, then backpressure and mid-command reset sequences.
module tb_uart_cmd_bridge;
    localparam int TO = 16;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_t;

    typedef struct {
        logic [31:0] by;
        int          nb;
        logic [7:0]  rdata;
        int          rdly;
        int          n_we;
        int          n_re;
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          has_tx;
        logic [7:0]  tx;
        int          n_err;
        int          to_kind;
    } vec_t;

    logic clk, reset_n, busy, err_pulse;

    uart_cmd_bridge_if #(.ADDR_W(16)) bif ();

    uart_cmd_bridge #(
        .ADDR_W    (16),
        .TO_CYCLES (TO),
        .TO_BIT    (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bif         (bif),
        .busy_o      (busy),
        .err_pulse_o (err_pulse)
    );

    logic [7:0] rxq[$];
    logic [7:0] pend[$];
    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];

    int checks = 0, errors = 0, cyc = 0;
    int n_rd = 0, n_wr = 0, n_we = 0, n_re = 0, n_err = 0;
    int last_rd_cyc = 0, wr_cyc = 0, re_cyc = 0, err_cyc = 0;
    int rv_cnt = 0, rd_dly = 0;
    logic [7:0] rd_val;
    bit rd_seen = 0, re_seen = 0, spur = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic [31:0] by, int nb, logic [7:0] rdata, int rdly,
                                int nwe, int nre, logic [15:0] addr, logic [7:0] wdata,
                                bit has_tx, logic [7:0] tx, int nerr, int to_kind);
        vec_t v;
        v.by = by; v.nb = nb; v.rdata = rdata; v.rdly = rdly;
        v.n_we = nwe; v.n_re = nre; v.addr = addr; v.wdata = wdata;
        v.has_tx = has_tx; v.tx = tx; v.n_err = nerr; v.to_kind = to_kind;
        return v;
    endfunction

    // Monitor: samples DUT outputs mid-cycle and scores them against the expectation queues.
    always @(negedge clk) begin
        bus_t b;
        cyc++;
        rd_seen = bif.rd_uart;
        re_seen = bif.bus_re;
        if (reset_n) begin
            if (bif.rd_uart) begin
                n_rd++;
                last_rd_cyc = cyc;
                chk("rd_uart while rx_empty", 32'(bif.rx_empty), 32'd0);
            end
            if (bif.wr_uart) begin
                n_wr++;
                wr_cyc = cyc;
                chk("wr_uart while tx_full", 32'(bif.tx_full), 32'd0);
                if (exp_tx.size() == 0) chk("unexpected tx byte", 32'(bif.w_data), 32'hFFFF_FFFF);
                else chk("tx byte", 32'(bif.w_data), 32'(exp_tx.pop_front()));
            end
            if (bif.bus_we || bif.bus_re) begin
                if (bif.bus_we) n_we++;
                if (bif.bus_re) begin n_re++; re_cyc = cyc; end
                if (exp_bus.size() == 0) begin
                    chk("unexpected bus strobe", 32'(bif.bus_addr), 32'hFFFF_FFFF);
                end else begin
                    b = exp_bus.pop_front();
                    chk("bus strobe kind", 32'(bif.bus_we), 32'(b.wr));
                    chk("bus addr", 32'(bif.bus_addr), 32'(b.addr));
                    if (b.wr) chk("bus wdata", 32'(bif.bus_wdata), 32'(b.data));
                end
            end
            if (err_pulse) begin
                n_err++;
                err_cyc = cyc;
            end
        end
    end

    // RX FIFO and bus slave models, updated just after each active edge.
    always @(posedge clk) begin
        #1;
        if (rd_seen && rxq.size() > 0) void'(rxq.pop_front());
        while (pend.size() > 0) rxq.push_back(pend.pop_front());
        bif.rx_empty   = (rxq.size() == 0);
        bif.r_data     = (rxq.size() == 0) ? 8'h00 : rxq[0];
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = 8'hEE;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                bif.bus_rvalid = 1'b1;
                bif.bus_rdata  = rd_val;
            end
        end
        if (re_seen && rd_dly > 0) begin
            if (rd_dly == 1) begin
                bif.bus_rvalid = 1'b1;
                bif.bus_rdata  = rd_val;
            end else begin
                rv_cnt = rd_dly - 1;
            end
        end
        if (spur) begin
            bif.bus_rvalid = 1'b1;
            bif.bus_rdata  = 8'hE7;
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic clr_counts();
        n_rd = 0; n_wr = 0; n_we = 0; n_re = 0; n_err = 0;
    endtask

    task automatic wait_idle(input string name, input int max);
        bit done = 0;
        int k = 0;
        while (!done && k < max) begin
            step();
            k++;
            done = (rxq.size() == 0) && (pend.size() == 0) && !busy && (exp_tx.size() == 0);
        end
        if (!done) chk({name, " idle timeout"}, 32'(k), 32'(max + 1));
        repeat (3) step();
        chk({name, " leftover bus expectations"}, 32'(exp_bus.size()), 32'd0);
        exp_bus.delete();
        exp_tx.delete();
    endtask

    task automatic chk_zero(input string name);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " err_pulse"}, 32'(err_pulse), 32'd0);
        chk({name, " rd_uart"}, 32'(bif.rd_uart), 32'd0);
        chk({name, " wr_uart"}, 32'(bif.wr_uart), 32'd0);
        chk({name, " bus_we"}, 32'(bif.bus_we), 32'd0);
        chk({name, " bus_re"}, 32'(bif.bus_re), 32'd0);
        chk({name, " w_data"}, 32'(bif.w_data), 32'd0);
        chk({name, " bus_addr"}, 32'(bif.bus_addr), 32'd0);
        chk({name, " bus_wdata"}, 32'(bif.bus_wdata), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        clr_counts();
        rd_val = v.rdata;
        rd_dly = v.rdly;
        if (v.has_tx) exp_tx.push_back(v.tx);
        if (v.n_we > 0) exp_bus.push_back('{1'b1, v.addr, v.wdata});
        if (v.n_re > 0) exp_bus.push_back('{1'b0, v.addr, 8'h00});
        for (int i = 0; i < v.nb; i++) pend.push_back(v.by[31 - 8*i -: 8]);
        wait_idle(nm, 300);
        chk({nm, " rd_uart pulses"}, 32'(n_rd), 32'(v.nb));
        chk({nm, " bus_we pulses"}, 32'(n_we), 32'(v.n_we));
        chk({nm, " bus_re pulses"}, 32'(n_re), 32'(v.n_re));
        chk({nm, " err pulses"}, 32'(n_err), 32'(v.n_err));
        chk({nm, " wr_uart pulses"}, 32'(n_wr), v.has_tx ? 32'd1 : 32'd0);
        if (v.to_kind == 1) chk({nm, " rx timeout latency"}, 32'(err_cyc - last_rd_cyc), 32'(TO));
        if (v.to_kind == 2) begin
            chk({nm, " read timeout err latency"}, 32'(err_cyc - re_cyc), 32'(TO));
            chk({nm, " read timeout tx latency"}, 32'(wr_cyc - re_cyc), 32'(TO + 1));
        end
    endtask

    initial begin
        vec_t vt [10];
        int k;
        reset_n        = 1'b0;
        bif.rx_empty   = 1'b1;
        bif.r_data     = 8'h00;
        bif.tx_full    = 1'b0;
        bif.bus_rdata  = 8'hEE;
        bif.bus_rvalid = 1'b0;
        rd_val         = 8'h00;

        //          bytes         nb rdata  dly we re addr      wdata  tx?  tx    err to
        vt[0] = mk(32'h571234A5, 4, 8'h00, 0,  1, 0, 16'h1234, 8'hA5, 1, 8'h4B, 0, 0);
        vt[1] = mk(32'h52001000, 3, 8'h3C, 3,  0, 1, 16'h0010, 8'h00, 1, 8'h3C, 0, 0);
        vt[2] = mk(32'h41000000, 1, 8'h00, 0,  0, 0, 16'h0000, 8'h00, 1, 8'h3F, 1, 0);
        vt[3] = mk(32'h52000000, 3, 8'h5A, 1,  0, 1, 16'h0000, 8'h00, 1, 8'h5A, 0, 0);
        vt[4] = mk(32'h77000000, 1, 8'h00, 0,  0, 0, 16'h0000, 8'h00, 1, 8'h3F, 1, 0);
        vt[5] = mk(32'h57FFFE00, 4, 8'h00, 0,  1, 0, 16'hFFFE, 8'h00, 1, 8'h4B, 0, 0);
        vt[6] = mk(32'h57120000, 2, 8'h00, 0,  0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 1);
        vt[7] = mk(32'h52ABCD00, 3, 8'h00, 0,  0, 1, 16'hABCD, 8'h00, 1, 8'h21, 1, 2);
        vt[8] = mk(32'h52800100, 3, 8'hC9, 15, 0, 1, 16'h8001, 8'h00, 1, 8'hC9, 0, 0);
        vt[9] = mk(32'h72000000, 1, 8'h00, 0,  0, 0, 16'h0000, 8'h00, 1, 8'h3F, 1, 0);

        repeat (3) step();
        chk_zero("reset");
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        // Backpressure: response held 50 cycles with a second command queued behind it.
        clr_counts();
        bif.tx_full = 1'b1;
        rd_val = 8'h77;
        rd_dly = 2;
        exp_tx.push_back(8'h4B);
        exp_tx.push_back(8'h77);
        exp_bus.push_back('{1'b1, 16'h0002, 8'h11});
        exp_bus.push_back('{1'b0, 16'h0002, 8'h00});
        pend.push_back(8'h57); pend.push_back(8'h00); pend.push_back(8'h02); pend.push_back(8'h11);
        pend.push_back(8'h52); pend.push_back(8'h00); pend.push_back(8'h02);
        k = 0;
        while (n_we == 0 && k < 30) begin step(); k++; end
        chk("bp write reached", 32'(n_we), 32'd1);
        for (int c = 0; c < 50; c++) begin
            spur = (c >= 20 && c < 23);
            step();
            chk("bp busy while held", 32'(busy), 32'd1);
        end
        spur = 1'b0;
        chk("bp wr_uart while full", 32'(n_wr), 32'd0);
        chk("bp rd_uart while held", 32'(n_rd), 32'd4);
        chk("bp rx bytes still queued", 32'(rxq.size()), 32'd3);
        bif.tx_full = 1'b0;
        wait_idle("bp", 300);
        chk("bp wr_uart pulses", 32'(n_wr), 32'd2);
        chk("bp rd_uart pulses", 32'(n_rd), 32'd7);
        chk("bp bus_re pulses", 32'(n_re), 32'd1);
        chk("bp err pulses", 32'(n_err), 32'd0);

        // Reset in the middle of a write command.
        clr_counts();
        pend.push_back(8'h57);
        pend.push_back(8'h12);
        k = 0;
        while (n_rd < 2 && k < 20) begin step(); k++; end
        chk("rst partial consumed", 32'(n_rd), 32'd2);
        chk("rst partial busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        rxq.delete();
        pend.delete();
        bif.rx_empty = 1'b1;
        bif.r_data = 8'h00;
        rv_cnt = 0;
        #1;
        chk_zero("mid reset");
        repeat (2) step();
        chk_zero("mid reset held");
        reset_n = 1'b1;
        step();
        chk("rst no reply", 32'(n_wr), 32'd0);
        run_vec(mk(32'h570001FF, 4, 8'h00, 0, 1, 0, 16'h0001, 8'hFF, 1, 8'h4B, 0, 0), 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global time limit: got expired, expected finish");
        $fatal(1, "time limit");
    end
endmodule
